// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives a combinational instruction memory and holds the
// fetched word in an IF/ID register with a valid/ready handshake and branch redirects.
module fetch_unit #(
   parameter int          WIDTH     = 32,
   parameter int          MEM_DEPTH = 16,
   parameter logic [31:0] RESET_PC  = 32'd0
) (
   input  logic             clk,
   input  logic             rst,
   output logic [31:0]      imem_pc,
   input  logic [WIDTH-1:0] imem_inst,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   input  logic [15:0]      redirect_offset,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_inst,
   output logic [31:0]      out_pc,
   output logic             halted,
   output logic [31:0]      fetch_count
);

   localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

   logic [31:0] pc_q;
   logic [31:0] target;
   logic        advance;
   logic        accept;
   logic        in_range;

   assign imem_pc  = pc_q;
   assign advance  = !out_valid || out_ready;
   assign accept   = out_valid && out_ready;
   assign in_range = pc_q < DEPTH;
   // Offset is a signed word count, so sign-extend before the modulo-2^32 add.
   assign target   = redirect_pc + {{16{redirect_offset[15]}}, redirect_offset};

   // NOTE: all state uses non-blocking assignments so every branch below reads the
   // pre-edge values of pc_q/out_valid/halted, exactly as the priority rules assume.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         out_valid   <= 1'b0;
         out_inst    <= '0;
         out_pc      <= '0;
         halted      <= 1'b0;
         fetch_count <= '0;
      end else begin
         // An accept counts even when a redirect flushes the register this cycle.
         if (accept) fetch_count <= fetch_count + 32'd1;

         if (redirect_valid) begin
            pc_q      <= target;
            halted    <= 1'b0;
            out_valid <= 1'b0;
         end else if (halted) begin
            if (accept) out_valid <= 1'b0;
         end else if (advance && in_range) begin
            out_inst  <= imem_inst;
            out_pc    <= pc_q;
            out_valid <= 1'b1;
            pc_q      <= pc_q + 32'd1;
         end else if (advance) begin
            halted    <= 1'b1;
            out_valid <= 1'b0;
         end
         // Remaining case is a stall: every register holds its value.
      end
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. Drives the word address into the combinational instruction memory and captures the returned instruction.
- Holds both in an IF/ID pipeline register with a valid/ready handshake toward decode.
- Takes branch redirects from execute as branch PC plus signed 16-bit offset, matching the BR encoding. Flushes the wrong-path instruction on redirect.
- Stops fetching when the PC leaves the instruction memory.

Parameters:
- WIDTH, `WIDTH (32): instruction width in bits.
- MEM_DEPTH, 16: number of instruction words; a PC >= MEM_DEPTH is out of range.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- imem_pc, output, 32: word address to the instruction memory; equals pc_q.
- imem_inst, input, WIDTH: instruction at imem_pc, valid in the same cycle (combinational memory).
- redirect_valid, input, 1: a taken branch resolved this cycle.
- redirect_pc, input, 32: PC of the taken branch.
- redirect_offset, input, 16: signed word offset (BR immediate field).
- out_valid, output, 1: IF/ID register holds a valid instruction.
- out_ready, input, 1: decode accepts IF/ID contents this cycle.
- out_inst, output, WIDTH: fetched instruction.
- out_pc, output, 32: PC of out_inst.
- halted, output, 1: fetch stopped because the PC went out of range.
- fetch_count, output, 32: number of instructions accepted by decode; wraps at 2^32.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - pc_q = RESET_PC.
  - out_valid = 0, out_inst = 0, out_pc = 0.
  - halted = 0, fetch_count = 0.
- Word addressing: the sequential next PC is pc_q + 1, mod 2^32.
- Redirect target = redirect_pc + sign-extended 32-bit redirect_offset, mod 2^32. Example: pc 5 with 0xFFFE gives 3.
- Definitions:
  - advance = !out_valid || out_ready.
  - accept = out_valid && out_ready; fetch_count increments on accept.
  - in_range = pc_q < MEM_DEPTH.
- Per-cycle priority, highest first:
  1. redirect_valid:
     - pc_q <= target; halted <= 0; out_valid <= 0 (wrong-path flush, independent of out_ready).
     - An accept in the same cycle still counts.
     - No fetch this cycle.
  2. halted:
     - pc_q holds.
     - On accept, out_valid <= 0; otherwise out_valid holds with its data.
  3. advance && in_range:
     - out_inst <= imem_inst; out_pc <= pc_q; out_valid <= 1; pc_q <= pc_q + 1.
  4. advance && !in_range:
     - halted <= 1; out_valid <= 0; pc_q holds.
  5. otherwise (out_valid && !out_ready):
     - Stall. pc_q, out_inst, out_pc and out_valid all hold.
- Latency:
  - Instruction at pc_q appears on out_inst one cycle after it is fetched.
  - Steady-state throughput is one instruction per cycle while out_ready = 1.
- Redirect penalty:
  - Cycle of redirect: out_valid = 0 on the next edge.
  - The target instruction is valid 2 edges after the redirect cycle.
- Stall stability: while out_valid = 1 and out_ready = 0, out_inst and out_pc must not change and imem_pc must be stable.
- Redirect to an out-of-range target: the next cycle takes rule 4; halted = 1 one edge later.
- Redirect while halted: clears halted and resumes at the target.
- Simultaneous redirect and stall: redirect wins; the stalled instruction is dropped and not counted.

Test Plan:
- Reset then out_ready = 1, memory loaded with the 6-word loop program (MOV, MOV, MOV, ADD, CMP, BR -2):
  - out_pc = 0,1,2,3,4,5 on consecutive cycles after first valid.
  - out_inst matches mem[n].
- At out_pc = 5, drive redirect_valid with redirect_pc = 5, redirect_offset = 0xFFFE:
  - Next cycle out_valid = 0.
  - Following cycle out_pc = 3.
  - The wrong-path word at pc 6 is never accepted.
- Hold out_ready = 0 for 4 cycles while out_pc = 2:
  - out_pc and out_inst stay stable.
  - imem_pc stays 3.
  - fetch_count unchanged.
  - On release, out_pc = 3 on the next edge.
- Run sequentially past pc 15 with no redirect:
  - After pc 15 is accepted, halted = 1 and out_valid = 0.
  - fetch_count = 16.
  - Then redirect to pc 0: halted = 0 and out_pc = 0 two edges later.
- Assert rst mid-stream at out_pc = 4 with out_valid = 1, asynchronously between edges:
  - Outputs go to reset values immediately.
  - imem_pc = 0.
  - fetch_count = 0.
- Redirect and out_ready = 0 in the same cycle with out_valid = 1: the instruction is flushed, fetch_count unchanged, and fetch resumes at the target.
